led_pattern_gen: RTL and testbench

Parametrised LED pattern generator for the board LED bank. It is the next generation of the fixed 8-bit shifting-LED block: width and step rate are parameters, and it adds eight modes, a run/pause enable and a step strobe. A free-running prescaler derives a step tick from the system clock, and a pattern register advances once per tick according to the selected mode. It sits between the board switches/buttons and the LED pins, and also serves as a pattern source for the LCD status line.

---
 rtl/led_pattern_gen.sv | 117 +++++++++++
 tb/tb_led_pattern_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern generator: a prescaler produces a step tick every DIV enabled clocks,
// and the pattern register advances once per tick according to the selected mode.
module led_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int DIV   = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic             step
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    M_OFF, M_CHASE_L, M_CHASE_R, M_PING, M_FILL, M_BLINK, M_COUNT, M_FREEZE
  } mode_e;

  typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_e;

  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  mode_e            mode_q, mode_d;
  logic             step_q, step_d;

  mode_e            mode_in;
  logic             tick;
  logic             restart;
  logic [WIDTH-1:0] init_val;
  logic [WIDTH-1:0] adv_val;
  dir_e             adv_dir;

  assign mode_in = mode_e'(mode);
  assign restart = (mode_in != mode_q);
  assign tick    = en && (cnt_q == CNT_MAX);

  // Value loaded on entry to a mode; freeze keeps whatever is showing.
  always_comb begin
    init_val = '0;
    case (mode_in)
      M_CHASE_L: init_val = WIDTH'(1);
      M_CHASE_R: init_val = {1'b1, {(WIDTH-1){1'b0}}};
      M_PING:    init_val = WIDTH'(1);
      M_FREEZE:  init_val = pat_q;
      default:   init_val = '0;
    endcase
  end

  always_comb begin
    adv_val = pat_q;
    adv_dir = dir_q;
    case (mode_q)
      M_OFF:     adv_val = '0;
      M_CHASE_L: adv_val = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
      M_CHASE_R: adv_val = {pat_q[0], pat_q[WIDTH-1:1]};
      M_PING: begin
        // Direction flips on the step that lands on an end LED, so each end shows once.
        if (dir_q == DIR_LEFT) begin
          adv_val = pat_q << 1;
          if (adv_val[WIDTH-1]) adv_dir = DIR_RIGHT;
        end else begin
          adv_val = pat_q >> 1;
          if (adv_val[0]) adv_dir = DIR_LEFT;
        end
      end
      M_FILL:    adv_val = (&pat_q) ? '0 : {pat_q[WIDTH-2:0], 1'b1};
      M_BLINK:   adv_val = ~pat_q;
      M_COUNT:   adv_val = pat_q + WIDTH'(1);
      M_FREEZE:  adv_val = pat_q;
      default:   adv_val = pat_q;
    endcase
  end

  always_comb begin
    mode_d = mode_in;
    pat_d  = pat_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    if (restart) begin
      pat_d = init_val;
      cnt_d = '0;
      dir_d = DIR_LEFT;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      if (tick) begin
        pat_d  = adv_val;
        dir_d  = adv_dir;
        step_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q  <= '0;
      cnt_q  <= '0;
      dir_q  <= DIR_LEFT;
      mode_q <= M_OFF;
      step_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      step_q <= step_d;
    end
  end

  assign q    = pat_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus random mode/enable/reset traffic,
// checked every cycle against a model that derives q from steps-since-restart.
module tb_led_pattern_gen;

  localparam int WIDTH = 8;
  localparam int DIV   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] q;
  logic             step;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int         m_prev;
  int         m_cnt;
  int         m_k;
  logic [7:0] m_q;
  logic       m_step;

  led_pattern_gen #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .mode (mode),
    .q    (q),
    .step (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Pattern shown k steps after entering mode m (freeze handled separately).
  function automatic logic [7:0] pattern(input int m, input int k);
    int p;
    case (m)
      1: return 8'(1 << (k % 8));
      2: return 8'(8'h80 >> (k % 8));
      3: begin
        p = k % 14;
        return 8'(1 << ((p < 8) ? p : 14 - p));
      end
      4: return 8'((1 << (k % 9)) - 1);
      5: return (k % 2 == 1) ? 8'hFF : 8'h00;
      6: return 8'(k % 256);
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_prev = 0;
    m_cnt  = 0;
    m_k    = 0;
    m_q    = 8'h00;
    m_step = 1'b0;
  endtask

  task automatic model_edge();
    int m;
    m = int'(mode);
    m_step = 1'b0;
    if (m != m_prev) begin
      m_cnt = 0;
      m_k   = 0;
      if (m != 7) m_q = pattern(m, 0);
    end else if (en) begin
      if (m_cnt == DIV - 1) begin
        m_cnt  = 0;
        m_k    = m_k + 1;
        m_step = 1'b1;
        if (m != 7) m_q = pattern(m, m_k);
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    m_prev = m;
  endtask

  task automatic clk_cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("q", 32'(q), 32'(m_q));
    chk("step", 32'(step), 32'(m_step));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) clk_cyc();
  endtask

  // Short asynchronous reset pulse well clear of any clock edge.
  task automatic reset_pulse();
    #2 reset = 1'b1;
    #1;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_step", 32'(step), 32'h0);
    model_reset();
    #1 reset = 1'b0;
  endtask

  logic [2:0] old_mode;
  int         r;

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    mode  = 3'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_q", 32'(q), 32'h0);
    chk("reset_step", 32'(step), 32'h0);

    mode  = 3'd1;
    en    = 1'b1;
    reset = 1'b0;
    run(40);

    mode = 3'd3;
    run(14 * DIV + 12);

    mode = 3'd4;
    run(30);
    mode = 3'd6;
    run(256 * DIV + 10);

    mode = 3'd5;
    run(6);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(12);

    mode = 3'd2;
    run(15);
    mode = 3'd7;
    run(20);
    mode = 3'd0;
    run(3);

    mode = 3'd1;
    run(10);
    reset_pulse();
    run(10);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        mode = 3'($urandom_range(0, 7));
      end else if (r == 3) begin
        old_mode = mode;
        mode = 3'($urandom_range(0, 7));
        clk_cyc();
        mode = old_mode;
      end else if (r >= 10 && r < 14) begin
        en = ~en;
      end else if (!en && r < 40) begin
        en = 1'b1;
      end else if (r == 99) begin
        reset_pulse();
      end
      clk_cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
